// File: rtl/dmrs_hop_seq_gen_pkg.sv
// Shared constants and FSM state type for the multi-symbol PUSCH DMRS
// group/sequence-hopping parameter generator.
package dmrs_hop_seq_gen_pkg;

  localparam logic [1:0] HOP_DIS = 2'd0;
  localparam logic [1:0] HOP_GH  = 2'd1;
  localparam logic [1:0] HOP_SH  = 2'd2;

  localparam int MOD_BASE = 30;
  localparam int MOD_W    = 5;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    COLLECT,
    REDUCE,
    OUT
  } state_t;

endpackage

// File: rtl/dmrs_hop_seq_gen_mod30_seq.sv
// Restoring mod-30 reducer: one conditional subtract of 30*2^k per cycle,
// k = STEPS-1 down to 0. done is high in the cycle whose result is on out.
module mod30_seq
  import dmrs_hop_seq_gen_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int STEPS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IN_W-1:0]  in,
  output logic             done,
  output logic [MOD_W-1:0] out
);

  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam int EXT_W = IN_W + STEPS + 6;

  logic [IN_W-1:0]  val_q;
  logic [IN_W-1:0]  val_nxt;
  logic [CNT_W-1:0] k_q;
  logic             run_q;
  logic [EXT_W-1:0] val_ext;
  logic [EXT_W-1:0] sub_w;

  // Compare in a widened domain so 30*2^k never overflows for any IN_W.
  always_comb begin
    val_ext = EXT_W'(val_q);
    sub_w   = EXT_W'(MOD_BASE) << k_q;
    val_nxt = val_q;
    if (val_ext >= sub_w) begin
      val_nxt = IN_W'(val_ext - sub_w);
    end
  end

  assign out  = val_nxt[MOD_W-1:0];
  assign done = run_q && (k_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      k_q   <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      val_q <= in;
      k_q   <= CNT_W'(STEPS - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      val_q <= val_nxt;
      if (k_q == '0) begin
        run_q <= 1'b0;
      end else begin
        k_q <= k_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmrs_hop_seq_gen.sv
// Per-slot DMRS hopping parameter generator: consumes Gold c bits, produces
// u/v/Mzc for NUM_SYMB symbols toward the Zadoff-Chu base-sequence generator.
module dmrs_hop_seq_gen
  import dmrs_hop_seq_gen_pkg::*;
#(
  parameter int NUM_SYMB = 4,
  parameter int NID_W    = 10,
  parameter int NRB_W    = 7,
  parameter int GH_BITS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NID_W-1:0] n_ID,
  input  logic [NRB_W-1:0] N_rb,
  input  logic [1:0]       En_hopping,
  input  logic             c_bit,
  input  logic             c_valid,
  output logic             c_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       u,
  output logic             v,
  output logic [NRB_W+2:0] Mzc,
  output logic [3:0]       sym_idx,
  output logic             busy
);

  localparam int S_W   = ((GH_BITS > 5) ? GH_BITS : 5) + 1;
  localparam int BC_W  = $clog2(GH_BITS) + 1;
  localparam int MZ_W  = NRB_W + 3;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds while valid&!ready.
  state_t               state_q;
  state_t               state_d;
  logic [1:0]           mode_q;
  logic [MOD_W-1:0]     nid_mod_q;
  logic [GH_BITS-1:0]   f_gh_q;
  logic [BC_W-1:0]      bit_cnt_q;
  logic [4:0]           u_q;
  logic                 v_q;
  logic [MZ_W-1:0]      mzc_q;
  logic [3:0]           sym_q;

  logic                 prep_load;
  logic                 prep_done;
  logic [MOD_W-1:0]     prep_out;
  logic                 red_load;
  logic                 red_done;
  logic [S_W-1:0]       red_in;
  logic [MOD_W-1:0]     red_out;
  logic                 c_acc;
  logic [GH_BITS-1:0]   fgh_acc;
  logic                 last_bit;
  logic                 last_sym;
  logic [1:0]           hop_sel;

  assign last_bit = (bit_cnt_q == BC_W'(GH_BITS - 1));
  assign last_sym = (sym_q == 4'(NUM_SYMB - 1));
  assign hop_sel  = (En_hopping == 2'd3) ? HOP_DIS : En_hopping;

  mod30_seq #(.IN_W(NID_W), .STEPS(6)) u_prep (
    .clk  (clk),
    .rst  (rst),
    .load (prep_load),
    .in   (n_ID),
    .done (prep_done),
    .out  (prep_out)
  );

  mod30_seq #(.IN_W(S_W), .STEPS(4)) u_reduce (
    .clk  (clk),
    .rst  (rst),
    .load (red_load),
    .in   (red_in),
    .done (red_done),
    .out  (red_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The REDUCE reducer is loaded on the edge that enters REDUCE, so its
  // operand is formed from the values that become valid on that same edge.
  always_comb begin
    state_d   = state_q;
    prep_load = 1'b0;
    red_load  = 1'b0;
    red_in    = S_W'(nid_mod_q);
    c_acc     = 1'b0;
    fgh_acc   = f_gh_q | (GH_BITS'(c_bit) << bit_cnt_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PREP;
          prep_load = 1'b1;
        end
      end
      PREP: begin
        if (prep_done) begin
          if (mode_q == HOP_DIS) begin
            state_d  = REDUCE;
            red_load = 1'b1;
            red_in   = S_W'(prep_out);
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        c_acc = c_valid;
        if (c_valid) begin
          if (mode_q == HOP_SH) begin
            state_d  = REDUCE;
            red_load = 1'b1;
          end else if (last_bit) begin
            state_d  = REDUCE;
            red_load = 1'b1;
            red_in   = S_W'(fgh_acc) + S_W'(nid_mod_q);
          end
        end
      end
      REDUCE: begin
        if (red_done) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (last_sym) begin
            state_d = IDLE;
          end else if (mode_q == HOP_DIS) begin
            state_d  = REDUCE;
            red_load = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= HOP_DIS;
      nid_mod_q <= '0;
      f_gh_q    <= '0;
      bit_cnt_q <= '0;
      u_q       <= '0;
      v_q       <= 1'b0;
      mzc_q     <= '0;
      sym_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= hop_sel;
            mzc_q     <= (MZ_W'(N_rb) << 2) + (MZ_W'(N_rb) << 1);
            sym_q     <= '0;
            f_gh_q    <= '0;
            bit_cnt_q <= '0;
            v_q       <= 1'b0;
          end
        end
        PREP: begin
          if (prep_done) begin
            nid_mod_q <= prep_out;
          end
        end
        COLLECT: begin
          if (c_acc) begin
            if (mode_q == HOP_SH) begin
              v_q <= c_bit;
            end else begin
              f_gh_q    <= fgh_acc;
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
            end
          end
        end
        REDUCE: begin
          if (red_done) begin
            u_q <= red_out;
          end
        end
        OUT: begin
          if (out_ready && !last_sym) begin
            sym_q     <= sym_q + 4'd1;
            f_gh_q    <= '0;
            bit_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign c_ready   = (state_q == COLLECT);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign u         = u_q;
  assign v         = v_q;
  assign Mzc       = mzc_q;
  assign sym_idx   = sym_q;

endmodule

// File: tb/tb_dmrs_hop_seq_gen.sv
// Directed bench for dmrs_hop_seq_gen: hand-computed u/v/Mzc per symbol,
// latency, c-bit consumption, backpressure, and mid-slot reset.
module tb_dmrs_hop_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] n_ID;
  logic [6:0] N_rb;
  logic [1:0] En_hopping;
  logic       c_bit;
  logic       c_valid;
  logic       c_ready;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] u;
  logic       v;
  logic [9:0] Mzc;
  logic [3:0] sym_idx;
  logic       busy;

  int         tb_total = 0;
  int         tb_bad   = 0;
  logic [9:0] exp_q[$];
  logic       c_src[$];
  logic [9:0] exp_mzc;
  int         c_used;
  bit         saw_c_ready;
  bit         bp_en;
  bit         c_toggle;
  int         bp_cnt;
  bit         tog;
  bit         held_pend;
  logic [10:0] held_v;

  dmrs_hop_seq_gen #(
    .NUM_SYMB (4),
    .NID_W    (10),
    .NRB_W    (7),
    .GH_BITS  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_ID       (n_ID),
    .N_rb       (N_rb),
    .En_hopping (En_hopping),
    .c_bit      (c_bit),
    .c_valid    (c_valid),
    .c_ready    (c_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .u          (u),
    .v          (v),
    .Mzc        (Mzc),
    .sym_idx    (sym_idx),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tb_total++;
    if (obs !== exp) begin
      tb_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) c_src.push_back(b[i]);
  endtask

  task automatic push_exp(input logic [4:0] eu, input logic ev, input int s);
    exp_q.push_back({4'(s), eu, ev});
  endtask

  // c-bit source, out_ready driver and scoreboard, all on the falling edge
  initial begin
    logic       dummy;
    logic [9:0] ev;
    c_valid = 1'b0; c_bit = 1'b0; out_ready = 1'b0;
    bp_cnt = 0; tog = 1'b0; held_pend = 1'b0; c_used = 0; saw_c_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (c_src.size() > 0 && !(c_toggle && tog)) begin
        c_valid = 1'b1;
        c_bit   = c_src[0];
      end else begin
        c_valid = 1'b0;
        c_bit   = 1'b0;
      end
      tog = !tog;
      out_ready = bp_en ? (out_valid && bp_cnt >= 5) : 1'b1;
      if (rst) begin
        held_pend = 1'b0;
        bp_cnt    = 0;
      end else begin
        if (c_ready) saw_c_ready = 1'b1;
        if (c_valid && c_ready) begin
          dummy = c_src.pop_front();
          c_used++;
        end
        if (held_pend) check("hold", {out_valid, sym_idx, u, v}, held_v);
        held_pend = out_valid && !out_ready;
        held_v    = {1'b1, sym_idx, u, v};
        if (out_valid && !out_ready) bp_cnt++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_out", exp_q.size(), 1);
          end else begin
            ev = exp_q.pop_front();
            check("out_sym_u_v", {sym_idx, u, v}, ev);
            check("out_mzc", Mzc, exp_mzc);
          end
          bp_cnt = 0;
        end
      end
    end
  end

  task automatic run_slot(input string tag, input logic [9:0] nid, input logic [6:0] nrb,
                          input logic [1:0] hop, input int lat_exp, input int c_exp);
    int lat;
    int n;
    exp_mzc = 10'(6 * int'(nrb));
    @(posedge clk); #1;
    c_used = 0; saw_c_ready = 1'b0;
    n_ID = nid; N_rb = nrb; En_hopping = hop; start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
    end while (!out_valid && lat < 200);
    if (lat_exp >= 0) check({tag, "_latency"}, lat, lat_exp);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_c_used"}, c_used, c_exp);
    check({tag, "_mzc_held"}, Mzc, exp_mzc);
    c_src.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; n_ID = '0; N_rb = '0; En_hopping = '0;
    bp_en = 1'b0; c_toggle = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_c_ready", c_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_u_v", {u, v}, 0);
    check("rst_mzc", Mzc, 0);
    check("rst_sym", sym_idx, 0);

    // disabled: 1023 mod 30 = 3, Mzc = 636
    for (int s = 0; s < 4; s++) push_exp(5'd3, 1'b0, s);
    run_slot("dis", 10'd1023, 7'd106, 2'd0, 11, 0);
    check("dis_no_c_ready", saw_c_ready, 0);

    // group hopping, all-ones: (255 + 10) mod 30 = 25
    for (int i = 0; i < 34; i++) c_src.push_back(1'b1);
    for (int s = 0; s < 4; s++) push_exp(5'd25, 1'b0, s);
    run_slot("gh_ones", 10'd100, 7'd25, 2'd1, 19, 32);

    // group hopping, f_gh = 30 with n_ID = 0, max N_rb
    for (int s = 0; s < 4; s++) begin
      push_byte(8'h1E);
      push_exp(5'd0, 1'b0, s);
    end
    run_slot("gh_30", 10'd0, 7'd127, 2'd1, 19, 32);

    // sequence hopping: 59 mod 30 = 29, v follows c stream
    c_src.push_back(1'b1); c_src.push_back(1'b0); c_src.push_back(1'b1);
    c_src.push_back(1'b0); c_src.push_back(1'b1); c_src.push_back(1'b1);
    push_exp(5'd29, 1'b1, 0); push_exp(5'd29, 1'b0, 1);
    push_exp(5'd29, 1'b1, 2); push_exp(5'd29, 1'b0, 3);
    run_slot("sh", 10'd59, 7'd1, 2'd2, 12, 4);

    // reserved mode behaves as disabled: 45 mod 30 = 15
    for (int s = 0; s < 4; s++) push_exp(5'd15, 1'b0, s);
    c_src.push_back(1'b1);
    run_slot("rsv", 10'd45, 7'd52, 2'd3, 11, 0);

    // varied f_gh per symbol, n_ID = 100: 0,255,129,60 -> 10,25,19,10
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h81); push_byte(8'h3C);
    push_exp(5'd10, 1'b0, 0); push_exp(5'd25, 1'b0, 1);
    push_exp(5'd19, 1'b0, 2); push_exp(5'd10, 1'b0, 3);
    run_slot("gh_var", 10'd100, 7'd10, 2'd1, 19, 32);

    // same slot with out_ready held low 5 cycles per symbol and c_valid toggling
    bp_en = 1'b1; c_toggle = 1'b1;
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h81); push_byte(8'h3C);
    push_exp(5'd10, 1'b0, 0); push_exp(5'd25, 1'b0, 1);
    push_exp(5'd19, 1'b0, 2); push_exp(5'd10, 1'b0, 3);
    run_slot("gh_stall", 10'd100, 7'd10, 2'd1, -1, 32);
    bp_en = 1'b0; c_toggle = 1'b0;

    // reset during COLLECT of symbol 1, with a start attempt while busy
    exp_mzc = 10'd300;
    @(posedge clk); #1;
    c_used = 0;
    for (int i = 0; i < 11; i++) c_src.push_back(1'b1);
    push_exp(5'd25, 1'b0, 0);
    n_ID = 10'd100; N_rb = 7'd50; En_hopping = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(c_used == 11 && sym_idx == 4'd1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("mid_sym", sym_idx, 1);
    check("mid_c_ready", c_ready, 1);
    check("mid_c_used", c_used, 11);
    n_ID = 10'd0; N_rb = 7'd3; En_hopping = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_mzc", Mzc, 300);
    check("busy_start_state", {busy, c_ready, sym_idx}, {1'b1, 1'b1, 4'd1});
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_c_ready", c_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_u_v", {u, v}, 0);
    check("mid_rst_mzc", Mzc, 0);
    check("mid_rst_sym", sym_idx, 0);
    rst = 1'b0;
    check("mid_rst_exp_left", exp_q.size(), 0);
    c_src.delete();

    // full slot after reset
    for (int s = 0; s < 4; s++) begin
      push_byte(8'h1E);
      push_exp(5'd0, 1'b0, s);
    end
    run_slot("post_rst", 10'd0, 7'd20, 2'd1, 19, 32);

    $display("test done: total=%0d bad=%0d", tb_total, tb_bad);
    $finish;
  end

endmodule

// File: doc/dmrs_hop_seq_gen.md
Name: dmrs_hop_seq_gen

Overview:
- Multi-symbol successor to the per-symbol PUSCH DMRS parameter generator.
- Per slot it serially consumes pseudo-random c bits, computes group number u and base-sequence number v for each of NUM_SYMB DMRS symbols, and reports Mzc = 6*N_rb.
- Sits between the Gold-sequence generator (upstream, c-bit stream) and the Zadoff-Chu base-sequence generator (downstream, per-symbol u/v/Mzc).
- Handshakes on both sides; mod-30 reduction is sequential.

Parameters:
- NUM_SYMB, 4, DMRS symbols processed per start (1..14).
- NID_W, 10, width of n_ID.
- NRB_W, 7, width of N_rb.
- GH_BITS, 8, c bits consumed per symbol when group hopping is enabled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle slot start; sampled only in IDLE
- n_ID  in  NID_W  scrambling identity; latched on accepted start
- N_rb  in  NRB_W  allocated RBs; latched on accepted start
- En_hopping  in  2  0 = disabled, 1 = group hopping, 2 = sequence hopping, 3 = reserved (treated as 0); latched on start
- c_bit  in  1  serial pseudo-random bit
- c_valid  in  1  c_bit valid
- c_ready  out  1  block accepts c_bit this cycle
- out_valid  out  1  u/v/Mzc/sym_idx valid
- out_ready  in  1  downstream accepts
- u  out  5  group number, 0..29
- v  out  1  sequence number
- Mzc  out  NRB_W+3  6*N_rb (latched value)
- sym_idx  out  4  symbol index 0..NUM_SYMB-1
- busy  out  1  high outside IDLE

Behaviour:
- Reset: state IDLE; c_ready, out_valid, busy, u, v, Mzc, sym_idx all 0. A reset asserted mid-slot aborts the slot with no further output, and pending c bits are not consumed.
- IDLE: on start=1, latch inputs, set Mzc=6*N_rb, set sym_idx=0, go to PREP. start in any other state is ignored.
- PREP: nid_mod = n_ID mod 30 by restoring reduction, one step per cycle, subtracting 30*2^k if value >= 30*2^k for k=5..0. This takes exactly 6 cycles. Then go to COLLECT, or directly to REDUCE when hopping is disabled (f_gh=0, v=0).
- COLLECT, group hopping:
  - c_ready=1; each c_valid&c_ready cycle adds c_bit<<m to f_gh (m=0..GH_BITS-1, LSB first).
  - After the GH_BITS-th accepted bit, go to REDUCE. Stalls (c_valid=0) hold state.
  - v=0.
- COLLECT, sequence hopping:
  - c_ready=1; exactly one accepted bit, v=c_bit, f_gh=0. Go to REDUCE.
- REDUCE:
  - s = f_gh + nid_mod (max 284, 9 bits).
  - Restoring reduction k=3..0 (240, 120, 60, 30), 4 cycles.
  - Result goes to u; go to OUT.
- OUT:
  - out_valid=1; u/v/sym_idx stable until out_valid&out_ready.
  - On handshake, out_valid falls next cycle.
  - If sym_idx==NUM_SYMB-1, go to IDLE; else increment sym_idx, clear f_gh, go to COLLECT (or REDUCE if disabled).
  - nid_mod is not recomputed per symbol.
- c_ready=0 outside COLLECT; c bits are never consumed in disabled mode.
- Latency, start to first out_valid, with no stalls:
  - Disabled: 1+6+4 = 11 cycles.
  - Group hopping: 11+GH_BITS.
  - Sequence hopping: 12.
- Per following symbol (no stalls): disabled 5 cycles (4 reduce + 1 handshake), group hopping GH_BITS+5, sequence hopping 6.
- Mzc is held from start until the next accepted start; it is not cleared on return to IDLE.

Decomposition:
- Shared package holds:
  - Hopping-mode constants: HOP_DIS=0, HOP_GH=1, HOP_SH=2.
  - FSM state enum: IDLE, PREP, COLLECT, REDUCE, OUT.
  - MOD_BASE=30.
- One natural sub-module, mod30_seq: restoring mod-30 reducer.
  - Parameters: input width and step count.
  - Ports: load, in, done, out.
  - Shared by PREP (6 steps) and REDUCE (4 steps).

Test Plan:
- Disabled mode: n_ID=1023, N_rb=106, NUM_SYMB=4, out_ready=1 -> four outputs, each u=3, v=0, Mzc=636, sym_idx 0..3; first out_valid 11 cycles after start; c_ready never high.
- Group hopping: n_ID=100, c bits all 1 -> each u=(255 mod 30 + 10) mod 30 = 25, v=0; exactly 32 c bits consumed.
- Group hopping: n_ID=0, c bits LSB-first 0,1,1,1,1,0,0,0 per symbol (f_gh=30) -> u=0 for every symbol.
- Sequence hopping: n_ID=59, c stream 1,0,1,0 -> (u,v) = (29,1), (29,0), (29,1), (29,0); exactly 4 bits consumed.
- Backpressure and stalls: out_ready low for 5 cycles and c_valid toggled -> outputs held stable, no bit lost or duplicated, identical u/v sequence to the unstalled run.
- Reset mid-slot: rst during COLLECT of symbol 1 -> next cycle all outputs 0 and IDLE. Start ignored while busy=1; a new start after reset produces a correct full slot.
